// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_mem_pkg
// Summary : Shared types and helpers for the unified memory port arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

    localparam int MIPS_ADDR_W = 30;
    localparam int MIPS_DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

    // Under contention the side that did not win last time goes next.
    function automatic grant_t pick_grant(input logic   want_if,
                                          input logic   want_dm,
                                          input grant_t last);
        if (want_dm && !(want_if && (last == GNT_DM))) begin
            return GNT_DM;
        end
        return GNT_IF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : mem_wait_timer
// Summary : 4-bit wait-state counter; done flags the last wait-state cycle.
// Rev     : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic done
);

    logic [3:0] cnt_d;
    logic [3:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 4'd0;
        end else if (en) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 4'(MEM_LAT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Summary : Shares one single-ported memory between fetch and load/store.
// Rev     : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = mips_mem_pkg::MIPS_ADDR_W,
    parameter int DATA_W  = mips_mem_pkg::MIPS_DATA_W,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_d,      state_q;
    grant_t            last_grant_d, last_grant_q;
    grant_t            owner_d,      owner_q;
    logic              mem_en_d,     mem_en_q;
    logic              mem_we_d,     mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d,   mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_d,  mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_d,   if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_d,   dm_rdata_q;
    logic              if_ack_d,     if_ack_q;
    logic              dm_ack_d,     dm_ack_q;

    logic   elig_if;
    logic   elig_dm;
    logic   timer_load;
    logic   timer_en;
    logic   timer_done;
    grant_t win;

    // A requester is masked during its own ack cycle so a held level
    // request is not mistaken for a fresh one.
    assign elig_if = if_req & ~if_ack_q;
    assign elig_dm = dm_req & ~dm_ack_q;
    assign win     = pick_grant(elig_if, elig_dm, last_grant_q);

    mem_wait_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .en    (timer_en),
        .done  (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        timer_load   = 1'b0;
        timer_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (elig_if || elig_dm) begin
                    state_d      = BUSY;
                    timer_load   = 1'b1;
                    owner_d      = win;
                    last_grant_d = win;
                    mem_en_d     = 1'b1;
                    if (win == GNT_DM) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            BUSY: begin
                timer_en = 1'b1;
                if (timer_done) begin
                    if (owner_q == GNT_IF) begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                        dm_ack_d = 1'b1;
                    end
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_IF;
            owner_q      <= GNT_IF;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = dm_req & ~dm_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Summary : Self-checking bench: vector table, corner sequences, random model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic          if_ack, dm_ack, stall_if, stall_mem, mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] l1_if_rdata, l1_dm_rdata, l1_mem_wdata, l1_mem_rdata;
    logic          l1_if_ack, l1_dm_ack, l1_stall_if, l1_stall_mem, l1_mem_en, l1_mem_we;
    logic [AW-1:0] l1_mem_addr;
    logic [DW-1:0] l15_if_rdata, l15_dm_rdata, l15_mem_wdata, l15_mem_rdata;
    logic          l15_if_ack, l15_dm_ack, l15_stall_if, l15_stall_mem, l15_mem_en, l15_mem_we;
    logic [AW-1:0] l15_mem_addr;

    logic [DW-1:0] env_mem [0:255];
    logic [DW-1:0] ref_mem [0:255];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign mem_rdata     = env_mem[mem_addr[7:0]];
    assign l1_mem_rdata  = env_mem[l1_mem_addr[7:0]];
    assign l15_mem_rdata = env_mem[l15_mem_addr[7:0]];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(l1_if_rdata), .if_ack(l1_if_ack),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr('0), .dm_wdata('0),
        .dm_rdata(l1_dm_rdata), .dm_ack(l1_dm_ack),
        .stall_if(l1_stall_if), .stall_mem(l1_stall_mem),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(15)) u_lat15 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(l15_if_rdata), .if_ack(l15_if_ack),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr('0), .dm_wdata('0),
        .dm_rdata(l15_dm_rdata), .dm_ack(l15_dm_ack),
        .stall_if(l15_stall_if), .stall_mem(l15_stall_mem),
        .mem_en(l15_mem_en), .mem_we(l15_mem_we), .mem_addr(l15_mem_addr),
        .mem_wdata(l15_mem_wdata), .mem_rdata(l15_mem_rdata)
    );

    function automatic logic [31:0] pat(input int i);
        if (i == 'h10) return 32'h2008_0005;
        return 32'hA500_0000 | 32'(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic cycle_begin();
        @(posedge clk);
        #1;
    endtask

    // Sample mid-cycle; the environment memory also commits stores here.
    task automatic cycle_sample();
        @(negedge clk);
        if (mem_en && mem_we) env_mem[mem_addr[7:0]] = mem_wdata;
    endtask

    task automatic drive(input logic r, input logic iq, input logic [7:0] ia,
                         input logic dq, input logic dw, input logic [7:0] da,
                         input logic [31:0] wd);
        rst_n    = r;
        if_req   = iq;
        if_addr  = AW'(ia);
        dm_req   = dq;
        dm_we    = dw;
        dm_addr  = AW'(da);
        dm_wdata = wd;
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2; k++) begin
            cycle_begin();
            drive('0, '0, 8'h00, '0, '0, 8'h00, 32'h0);
            cycle_sample();
        end
    endtask

    typedef struct {
        logic        r, iq;
        logic [7:0]  ia;
        logic        dq, dw;
        logic [7:0]  da;
        logic [31:0] wd;
        logic        e_ifa, e_dma, e_en, e_we;
        logic [7:0]  e_ma;
        logic        e_sif, e_sm;
        logic [31:0] e_ifr, e_dmr;
    } vec_t;

    localparam logic [31:0] F   = 32'h2008_0005;
    localparam logic [31:0] M12 = 32'hA500_0012;
    localparam logic [31:0] M13 = 32'hA500_0013;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;

    vec_t tv [26];

    // Random-phase model state
    int          has_txn, owner, gnt_c, ack_c, last_dm, la;
    logic        lwe, e_ifa, e_dma, e_en, e_we, el_if, el_dm, take_dm;
    logic        if_pend, dm_pend, p_if_ack, p_dm_ack;
    logic [31:0] rdi, rdd;
    logic [7:0]  m_addr;

    initial begin
        for (int i = 0; i < 256; i++) env_mem[i] = pat(i);
        drive('0, '0, 8'h00, '0, '0, 8'h00, 32'h0);

        //                r   iq  ia     dq  dw  da     wd      ifa dma en  we  ma     sif sm  ifr  dmr
        tv[0]  = '{'0, '0, 8'h00, '0, '0, 8'h00, 32'h0, '0, '0, '0, '0, 8'h00, '0, '0, 32'h0, 32'h0};
        tv[1]  = '{'1, '1, 8'h10, '0, '0, 8'h00, 32'h0, '0, '0, '0, '0, 8'h00, '1, '0, 32'h0, 32'h0};
        tv[2]  = '{'1, '1, 8'h10, '0, '0, 8'h00, 32'h0, '0, '0, '1, '0, 8'h10, '1, '0, 32'h0, 32'h0};
        tv[3]  = tv[2];
        tv[4]  = '{'1, '1, 8'h10, '0, '0, 8'h00, 32'h0, '1, '0, '0, '0, 8'h10, '0, '0, F, 32'h0};
        tv[5]  = '{'1, '0, 8'h00, '0, '0, 8'h00, 32'h0, '0, '0, '0, '0, 8'h10, '0, '0, F, 32'h0};
        tv[6]  = '{'1, '0, 8'h00, '1, '1, 8'h20, DB,    '0, '0, '0, '0, 8'h10, '0, '1, F, 32'h0};
        tv[7]  = '{'1, '0, 8'h00, '1, '1, 8'h20, DB,    '0, '0, '1, '1, 8'h20, '0, '1, F, 32'h0};
        tv[8]  = tv[7];
        tv[9]  = '{'1, '0, 8'h00, '1, '1, 8'h20, DB,    '0, '1, '0, '0, 8'h20, '0, '0, F, 32'h0};
        tv[10] = '{'1, '0, 8'h00, '0, '0, 8'h00, 32'h0, '0, '0, '0, '0, 8'h20, '0, '0, F, 32'h0};
        tv[11] = tv[0];
        tv[12] = '{'1, '1, 8'h12, '1, '0, 8'h13, 32'h0, '0, '0, '0, '0, 8'h00, '1, '1, 32'h0, 32'h0};
        tv[13] = '{'1, '1, 8'h12, '1, '0, 8'h13, 32'h0, '0, '0, '1, '0, 8'h13, '1, '1, 32'h0, 32'h0};
        tv[14] = tv[13];
        tv[15] = '{'1, '1, 8'h12, '1, '0, 8'h13, 32'h0, '0, '1, '0, '0, 8'h13, '1, '0, 32'h0, M13};
        tv[16] = '{'1, '1, 8'h12, '1, '0, 8'h13, 32'h0, '0, '0, '1, '0, 8'h12, '1, '1, 32'h0, M13};
        tv[17] = tv[16];
        tv[18] = '{'1, '1, 8'h12, '1, '0, 8'h13, 32'h0, '1, '0, '0, '0, 8'h12, '0, '1, M12, M13};
        tv[19] = '{'1, '1, 8'h12, '1, '0, 8'h13, 32'h0, '0, '0, '1, '0, 8'h13, '1, '1, M12, M13};
        tv[20] = tv[19];
        tv[21] = '{'1, '1, 8'h12, '1, '0, 8'h13, 32'h0, '0, '1, '0, '0, 8'h13, '1, '0, M12, M13};
        tv[22] = '{'1, '0, 8'h00, '0, '0, 8'h00, 32'h0, '0, '0, '1, '0, 8'h12, '0, '0, M12, M13};
        tv[23] = tv[22];
        tv[24] = '{'1, '0, 8'h00, '0, '0, 8'h00, 32'h0, '1, '0, '0, '0, 8'h12, '0, '0, M12, M13};
        tv[25] = '{'1, '0, 8'h00, '0, '0, 8'h00, 32'h0, '0, '0, '0, '0, 8'h12, '0, '0, M12, M13};

        do_reset();
        for (int i = 0; i < 26; i++) begin
            cycle_begin();
            drive(tv[i].r, tv[i].iq, tv[i].ia, tv[i].dq, tv[i].dw, tv[i].da, tv[i].wd);
            cycle_sample();
            chk($sformatf("tv%0d if_ack", i),    32'(if_ack),    32'(tv[i].e_ifa));
            chk($sformatf("tv%0d dm_ack", i),    32'(dm_ack),    32'(tv[i].e_dma));
            chk($sformatf("tv%0d mem_en", i),    32'(mem_en),    32'(tv[i].e_en));
            chk($sformatf("tv%0d mem_we", i),    32'(mem_we),    32'(tv[i].e_we));
            chk($sformatf("tv%0d mem_addr", i),  32'(mem_addr),  32'(tv[i].e_ma));
            chk($sformatf("tv%0d stall_if", i),  32'(stall_if),  32'(tv[i].e_sif));
            chk($sformatf("tv%0d stall_mem", i), 32'(stall_mem), 32'(tv[i].e_sm));
            chk($sformatf("tv%0d if_rdata", i),  if_rdata,       tv[i].e_ifr);
            chk($sformatf("tv%0d dm_rdata", i),  dm_rdata,       tv[i].e_dmr);
            if (tv[i].e_we) chk($sformatf("tv%0d mem_wdata", i), mem_wdata, tv[i].wd);
        end

        // Back-to-back fetches on a held request: acks at 3 and 7 only.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            cycle_begin();
            drive('1, (c <= 7) ? 1'b1 : 1'b0, (c >= 4) ? 8'h11 : 8'h10, '0, '0, 8'h00, 32'h0);
            cycle_sample();
            chk($sformatf("b2b c%0d if_ack", c), 32'(if_ack), 32'((c == 3) || (c == 7)));
            if (c == 3) chk("b2b first rdata", if_rdata, F);
            if (c == 5) chk("b2b second addr", 32'(mem_addr), 32'h11);
            if (c == 7) chk("b2b second rdata", if_rdata, 32'hA500_0011);
        end

        // Reset in cycle 2 of a load; reissued load acks at 4+LAT+1.
        for (int c = 0; c < 10; c++) begin
            cycle_begin();
            drive((c == 2 || c == 3) ? 1'b0 : 1'b1, '0, 8'h00, (c <= 7) ? 1'b1 : 1'b0, '0, 8'h30, 32'h0);
            cycle_sample();
            chk($sformatf("rst c%0d dm_ack", c), 32'(dm_ack), 32'(c == 4 + LAT + 1));
            if (c == 1) chk("rst pre mem_en", 32'(mem_en), 32'h1);
            if (c == 2) begin
                chk("rst mem_en", 32'(mem_en), 32'h0);
                chk("rst mem_addr", 32'(mem_addr), 32'h0);
                chk("rst if_rdata", if_rdata, 32'h0);
                chk("rst dm_rdata", dm_rdata, 32'h0);
            end
            if (c == 5) chk("rst reissue mem_en", 32'(mem_en), 32'h1);
            if (c == 7) chk("rst reissue rdata", dm_rdata, pat('h30));
        end

        // MEM_LAT=1 and MEM_LAT=15 single fetches.
        do_reset();
        for (int c = 0; c < 18; c++) begin
            cycle_begin();
            drive('1, (c <= 16) ? 1'b1 : 1'b0, 8'h10, '0, '0, 8'h00, 32'h0);
            cycle_sample();
            if (c <= 3) chk($sformatf("lat1 c%0d if_ack", c), 32'(l1_if_ack), 32'(c == 2));
            chk($sformatf("lat15 c%0d if_ack", c), 32'(l15_if_ack), 32'(c == 16));
            if (c == 2)  chk("lat1 rdata", l1_if_rdata, F);
            if (c == 16) chk("lat15 rdata", l15_if_rdata, F);
        end

        // Random traffic against a transaction-timeline model.
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        has_txn = 0; owner = 0; gnt_c = 0; ack_c = 0; last_dm = 0; la = 0;
        lwe = 0; rdi = 0; rdd = 0; m_addr = 0;
        if_pend = 0; dm_pend = 0; p_if_ack = 0; p_dm_ack = 0;
        for (int c = 0; c < 600; c++) begin
            cycle_begin();
            rst_n = (c < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
            if (p_if_ack) if_pend = 0;
            if (p_dm_ack) dm_pend = 0;
            if (!if_pend && $urandom_range(0, 1) == 1) begin
                if_pend = 1;
                if_addr = AW'($urandom_range(64, 255));
            end
            if (!dm_pend && $urandom_range(0, 1) == 1) begin
                dm_pend  = 1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = AW'($urandom_range(64, 255));
                dm_wdata = $urandom;
            end
            if_req = if_pend;
            dm_req = dm_pend;
            cycle_sample();

            e_ifa = 0; e_dma = 0; e_en = 0; e_we = 0;
            if (!rst_n) begin
                has_txn = 0; last_dm = 0; rdi = 0; rdd = 0; m_addr = 0; ack_c = c;
            end else if (has_txn != 0) begin
                e_ifa = (c == ack_c) && (owner == 0);
                e_dma = (c == ack_c) && (owner == 1);
                e_en  = (c > gnt_c) && (c < ack_c);
                e_we  = e_en && lwe;
                if (e_ifa) rdi = ref_mem[la];
                if (e_dma && !lwe) rdd = ref_mem[la];
            end
            chk($sformatf("rnd c%0d if_ack", c),    32'(if_ack),    32'(e_ifa));
            chk($sformatf("rnd c%0d dm_ack", c),    32'(dm_ack),    32'(e_dma));
            chk($sformatf("rnd c%0d mem_en", c),    32'(mem_en),    32'(e_en));
            chk($sformatf("rnd c%0d mem_we", c),    32'(mem_we),    32'(e_we));
            chk($sformatf("rnd c%0d mem_addr", c),  32'(mem_addr),  32'(m_addr));
            chk($sformatf("rnd c%0d stall_if", c),  32'(stall_if),  32'(if_req && !e_ifa));
            chk($sformatf("rnd c%0d stall_mem", c), 32'(stall_mem), 32'(dm_req && !e_dma));
            chk($sformatf("rnd c%0d if_rdata", c),  if_rdata,       rdi);
            chk($sformatf("rnd c%0d dm_rdata", c),  dm_rdata,       rdd);

            if (rst_n && (has_txn == 0 || c >= ack_c)) begin
                el_if = if_req && !e_ifa;
                el_dm = dm_req && !e_dma;
                if (el_if || el_dm) begin
                    take_dm = el_dm && !(el_if && last_dm == 1);
                    has_txn = 1;
                    gnt_c   = c;
                    ack_c   = c + LAT + 1;
                    owner   = take_dm ? 1 : 0;
                    last_dm = take_dm ? 1 : 0;
                    la      = take_dm ? int'(dm_addr[7:0]) : int'(if_addr[7:0]);
                    lwe     = take_dm && dm_we;
                    m_addr  = 8'(la);
                    if (lwe) ref_mem[la] = dm_wdata;
                end
            end
            p_if_ack = e_ifa;
            p_dm_ack = e_dma;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
